// File: rtl/aud_recorder.sv
// I2S left-channel capture for the WM8731 ADC: deserialises 16-bit samples and pairs each with a
// sequential SRAM word address. Define AUD_REC_LEN_EN to add the o_length sample counter.
module aud_recorder #(
    parameter logic [19:0] ADDR_MAX = 20'hFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lrc,
    input  logic        i_data,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    output logic [15:0] o_data,
    output logic [19:0] o_address,
    output logic        o_valid,
    output logic        o_full,
    output logic        o_recording
`ifdef AUD_REC_LEN_EN
    ,
    output logic [19:0] o_length
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_SKIP  = 3'd2;
    localparam logic [2:0] S_RECV  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_lrc_d;
    logic [15:0] r_shift;
    logic [3:0]  r_bit_cnt;
    logic [19:0] r_addr_cnt;
    logic [15:0] r_data;
    logic [19:0] r_address;
    logic        r_valid;
    logic        r_full;

    logic        w_lrc_fall;
    logic        w_active;
    logic        w_last_bit;
    logic        w_capture;
    logic        w_full_hit;
    logic        w_new_take;
    logic [15:0] w_word;

    assign w_lrc_fall = r_lrc_d & ~i_lrc;
    assign w_active   = (r_state == S_WAIT) || (r_state == S_SKIP) || (r_state == S_RECV);
    assign w_last_bit = (r_state == S_RECV) && (r_bit_cnt == 4'd15);
    assign w_word     = {r_shift[14:0], i_data};

    // A coinciding stop or pause on the LSB edge wins over the strobe.
    assign w_capture  = w_last_bit && !i_stop && !i_pause;
    assign w_full_hit = w_capture && (r_addr_cnt == ADDR_MAX);
    assign w_new_take = (r_state == S_IDLE) && i_start && !i_stop && !i_pause;

    always_comb begin
        w_state_nxt = r_state;
        if (i_stop) begin
            w_state_nxt = S_IDLE;
        end else if (i_pause) begin
            if (w_active) begin
                w_state_nxt = S_PAUSE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_PAUSE: begin
                    if (i_start) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_lrc_fall) begin
                        w_state_nxt = S_SKIP;
                    end
                end
                S_SKIP: begin
                    w_state_nxt = S_RECV;
                end
                S_RECV: begin
                    if (r_bit_cnt == 4'd15) begin
                        w_state_nxt = w_full_hit ? S_IDLE : S_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_lrc_d    <= 1'b0;
            r_shift    <= 16'd0;
            r_bit_cnt  <= 4'd0;
            r_addr_cnt <= 20'd0;
            r_data     <= 16'd0;
            r_address  <= 20'd0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lrc_d <= i_lrc;
            r_valid <= w_capture;

            if (w_new_take) begin
                r_addr_cnt <= 20'd0;
                r_full     <= 1'b0;
            end

            // The SKIP edge carries no data; the bit counter restarts so aborted samples are dropped.
            if (r_state == S_SKIP) begin
                r_bit_cnt <= 4'd0;
            end else if (r_state == S_RECV) begin
                r_shift   <= w_word;
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_capture) begin
                r_data    <= w_word;
                r_address <= r_addr_cnt;
                if (w_full_hit) begin
                    r_full <= 1'b1;
                end else begin
                    r_addr_cnt <= r_addr_cnt + 20'd1;
                end
            end
        end
    end

`ifdef AUD_REC_LEN_EN
    logic [19:0] r_length;

    // Stops advancing at ADDR_MAX+1 because a full store forces IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_length <= 20'd0;
        end else if (w_new_take) begin
            r_length <= 20'd0;
        end else if (w_capture) begin
            r_length <= r_length + 20'd1;
        end
    end

    assign o_length = r_length;
`endif

    assign o_data      = r_data;
    assign o_address   = r_address;
    assign o_valid     = r_valid;
    assign o_full      = r_full;
    assign o_recording = (r_state == S_WAIT) || (r_state == S_RECV);

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: default-size instance plus an ADDR_MAX=3 instance for the full case.
module tb_aud_recorder;

    localparam logic [2:0] CMD_NONE  = 3'b000;
    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_PAUSE = 3'b010;
    localparam logic [2:0] CMD_STOP  = 3'b100;

    typedef struct {
        logic        restart;
        logic [15:0] left;
        logic [15:0] right;
        logic [19:0] exp_addr;
    } frame_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_small_n;
    logic        i_lrc;
    logic        i_data;
    logic        i_start;
    logic        i_pause;
    logic        i_stop;

    logic [15:0] o_data;
    logic [19:0] o_address;
    logic        o_valid;
    logic        o_full;
    logic        o_recording;
    logic [15:0] s_data;
    logic [19:0] s_address;
    logic        s_valid;
    logic        s_full;
    logic        s_recording;
`ifdef AUD_REC_LEN_EN
    logic [19:0] o_length;
    logic [19:0] s_length;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [35:0] exp_q[$];
    logic [35:0] exp_small_q[$];
    logic [35:0] e_main;
    logic [35:0] e_small;
    frame_vec_t  vecs[4];
    logic [15:0] small_words[4];

    always #5 clk = ~clk;

    aud_recorder u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_lrc       (i_lrc),
        .i_data      (i_data),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_stop      (i_stop),
        .o_data      (o_data),
        .o_address   (o_address),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_recording (o_recording)
`ifdef AUD_REC_LEN_EN
        ,
        .o_length    (o_length)
`endif
    );

    aud_recorder #(.ADDR_MAX(20'd3)) u_dut_small (
        .i_clk       (clk),
        .i_rst_n     (rst_small_n),
        .i_lrc       (i_lrc),
        .i_data      (i_data),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_stop      (i_stop),
        .o_data      (s_data),
        .o_address   (s_address),
        .o_valid     (s_valid),
        .o_full      (s_full),
        .o_recording (s_recording)
`ifdef AUD_REC_LEN_EN
        ,
        .o_length    (s_length)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboards: every strobe must match the head of its expected queue.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL main_strobe: got addr %h data %h, expected no strobe", o_address, o_data);
            end else begin
                e_main = exp_q.pop_front();
                if ({o_address, o_data} !== e_main) begin
                    n_errors++;
                    $display("FAIL main_strobe: got addr %h data %h, expected addr %h data %h",
                             o_address, o_data, e_main[35:16], e_main[15:0]);
                end
            end
        end
        if (s_valid === 1'b1) begin
            n_checks++;
            if (exp_small_q.size() == 0) begin
                n_errors++;
                $display("FAIL small_strobe: got addr %h data %h, expected no strobe", s_address, s_data);
            end else begin
                e_small = exp_small_q.pop_front();
                if ({s_address, s_data} !== e_small) begin
                    n_errors++;
                    $display("FAIL small_strobe: got addr %h data %h, expected addr %h data %h",
                             s_address, s_data, e_small[35:16], e_small[15:0]);
                end
            end
        end
    end

    task automatic clk_bit(input logic lrc, input logic d, input logic [2:0] cmd);
        @(negedge clk);
        i_lrc   = lrc;
        i_data  = d;
        i_stop  = cmd[2];
        i_pause = cmd[1];
        i_start = cmd[0];
    endtask

    // 20-bit half frame: delay bit, skip bit, 16 data bits MSB first, 2 pad bits.
    task automatic send_half(input logic lrc, input logic [15:0] w,
                             input int idx_a, input logic [2:0] cmd_a,
                             input int idx_b, input logic [2:0] cmd_b);
        for (int i = 0; i < 20; i++) begin
            logic       b;
            logic [2:0] c;
            b = 1'b0;
            if (i >= 2 && i < 18) b = w[17 - i];
            c = CMD_NONE;
            if (i == idx_a) c = cmd_a;
            else if (i == idx_b) c = cmd_b;
            clk_bit(lrc, b, c);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rst_small_n = 1'b0;
        i_lrc       = 1'b0;
        i_data      = 1'b0;
        i_start     = 1'b0;
        i_pause     = 1'b0;
        i_stop      = 1'b0;

        vecs[0] = '{1'b1, 16'hA55A, 16'h1234, 20'd0};
        vecs[1] = '{1'b1, 16'h0001, 16'h1234, 20'd0};
        vecs[2] = '{1'b0, 16'h8000, 16'h1234, 20'd1};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h1234, 20'd2};
        small_words[0] = 16'h1111;
        small_words[1] = 16'h2222;
        small_words[2] = 16'h4444;
        small_words[3] = 16'h8888;

        repeat (3) @(negedge clk);
        check("reset_data", 32'(o_data), 32'h0);
        check("reset_address", 32'(o_address), 32'h0);
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_full", 32'(o_full), 32'h0);
        check("reset_recording", 32'(o_recording), 32'h0);
        rst_n = 1'b1;

        // Single frame, then three back-to-back frames after a stop/start.
        foreach (vecs[k]) begin
            if (vecs[k].restart) send_half(1'b1, 16'h1234, 3, CMD_STOP, 6, CMD_START);
            exp_q.push_back({vecs[k].exp_addr, vecs[k].left});
            send_half(1'b0, vecs[k].left, -1, CMD_NONE, -1, CMD_NONE);
            send_half(1'b1, vecs[k].right, -1, CMD_NONE, -1, CMD_NONE);
        end
        check("table_recording", 32'(o_recording), 32'h1);
        check("table_last_data", 32'(o_data), 32'hFFFF);
        check("table_full", 32'(o_full), 32'h0);

        // Pause at data bit 8, resume, next frame goes to the next address.
        send_half(1'b0, 16'hC3C3, 10, CMD_PAUSE, -1, CMD_NONE);
        check("pause_recording", 32'(o_recording), 32'h0);
        send_half(1'b1, 16'h1234, 5, CMD_START, -1, CMD_NONE);
        check("resume_recording", 32'(o_recording), 32'h1);
        exp_q.push_back({20'd3, 16'h7F00});
        send_half(1'b0, 16'h7F00, -1, CMD_NONE, -1, CMD_NONE);
        send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);

        // Stop+pause+start together in RECV must behave as stop (restart from address 0).
        send_half(1'b0, 16'h5555, 9, CMD_STOP | CMD_PAUSE | CMD_START, -1, CMD_NONE);
        check("allcmd_recording", 32'(o_recording), 32'h0);
        check("allcmd_data_hold", 32'(o_data), 32'h7F00);
        check("allcmd_addr_hold", 32'(o_address), 32'h3);
        send_half(1'b1, 16'h1234, 5, CMD_START, -1, CMD_NONE);
        exp_q.push_back({20'd0, 16'h1357});
        send_half(1'b0, 16'h1357, -1, CMD_NONE, -1, CMD_NONE);
        send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);
        exp_q.push_back({20'd1, 16'h2468});
        send_half(1'b0, 16'h2468, -1, CMD_NONE, -1, CMD_NONE);
        send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 10; i++) begin
            logic [15:0] w;
            logic        b;
            w = 16'h6C6C;
            b = 1'b0;
            if (i >= 2) b = w[17 - i];
            clk_bit(1'b0, b, CMD_NONE);
        end
        @(posedge clk);
        #2;
        check("prereset_recording", 32'(o_recording), 32'h1);
        check("prereset_address", 32'(o_address), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_data", 32'(o_data), 32'h0);
        check("async_address", 32'(o_address), 32'h0);
        check("async_valid", 32'(o_valid), 32'h0);
        check("async_full", 32'(o_full), 32'h0);
        check("async_recording", 32'(o_recording), 32'h0);

        // Fill the ADDR_MAX=3 instance; main instance stays in reset.
        @(negedge clk);
        rst_small_n = 1'b1;
        send_half(1'b1, 16'h1234, 5, CMD_START, -1, CMD_NONE);
        for (int k = 0; k < 4; k++) begin
            exp_small_q.push_back({20'(k), small_words[k]});
            send_half(1'b0, small_words[k], -1, CMD_NONE, -1, CMD_NONE);
            send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);
        end
        check("small_full", 32'(s_full), 32'h1);
        check("small_full_recording", 32'(s_recording), 32'h0);
        check("small_full_address", 32'(s_address), 32'h3);
`ifdef AUD_REC_LEN_EN
        check("small_length", 32'(s_length), 32'h4);
`endif
        send_half(1'b0, 16'hDEAD, -1, CMD_NONE, -1, CMD_NONE);
        send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);
        check("small_full_held", 32'(s_full), 32'h1);
        send_half(1'b1, 16'h1234, 5, CMD_START, -1, CMD_NONE);
        check("small_restart_full", 32'(s_full), 32'h0);
        check("small_restart_recording", 32'(s_recording), 32'h1);
        exp_small_q.push_back({20'd0, 16'hBEEF});
        send_half(1'b0, 16'hBEEF, -1, CMD_NONE, -1, CMD_NONE);
        send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);
        check("small_restart_address", 32'(s_address), 32'h0);

`ifdef AUD_REC_LEN_EN
        // Sample count survives a stop and clears on the next start.
        rst_small_n = 1'b0;
        rst_n       = 1'b1;
        send_half(1'b1, 16'h1234, 5, CMD_START, -1, CMD_NONE);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({20'(k), 16'h0100 + 16'(k)});
            send_half(1'b0, 16'h0100 + 16'(k), -1, CMD_NONE, -1, CMD_NONE);
            send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);
        end
        send_half(1'b1, 16'h1234, 5, CMD_STOP, -1, CMD_NONE);
        check("length_after_stop", 32'(o_length), 32'h5);
        check("length_stop_recording", 32'(o_recording), 32'h0);
        send_half(1'b0, 16'h9999, -1, CMD_NONE, -1, CMD_NONE);
        send_half(1'b1, 16'h1234, -1, CMD_NONE, -1, CMD_NONE);
        check("length_held", 32'(o_length), 32'h5);
        send_half(1'b1, 16'h1234, 5, CMD_START, -1, CMD_NONE);
        check("length_cleared", 32'(o_length), 32'h0);
`endif

        repeat (3) @(negedge clk);
        check("main_queue_drained", 32'(exp_q.size()), 32'h0);
        check("small_queue_drained", 32'(exp_small_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
